overlay_sdram_arbiter: RTL and testbench
========================================

# overlay_sdram_arbiter

Shares SDRAM channel 1 between the overlay download writer and the overlay pixel prefetcher. It buffers prefetched 32-bit words in a small FIFO and serves them to the display as 16-bit RGBA4444 pixels. Arbitration is by priority, with a low-water override that protects the display, plus a per-access timeout. The block sits between the download/display logic in emu and the sdram controller.

## Interface
- ADDR_W, 24: word address width; one word = 16 bits.
- FIFO_DEPTH, 8: number of prefetch entries, 32 bits each; power of two.
- LOW_WATER, 2: FIFO level below which a read beats a pending write.
- TIMEOUT, 255: cycles to wait for mem_ack before abandoning an access.

Ports (name, direction, width, meaning):
- clk_sys, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- wr_req, in, 1: one-cycle pulse that offers a download write; sampled only when wr_busy=0.
- wr_addr, in, ADDR_W: word address for the write.
- wr_data, in, 16: write data.
- wr_busy, out, 1: a write is pending or in flight.
- frame_start, in, 1: pulse. Flushes the FIFO, loads rd_base and enables prefetch.
- rd_base, in, ADDR_W: first word address of the frame; bit 0 is ignored (even-aligned).
- pix_pop, in, 1: consume one pixel.
- pix_valid, out, 1: pix_data is valid.
- pix_data, out, 16: current pixel.
- underrun_cnt, out, 8: pops seen while pix_valid=0; saturates at 255; cleared by frame_start.
- err_timeout, out, 1: sticky; cleared only by reset.
- mem_req, out, 1: one-cycle request strobe.
- mem_rnw, out, 1: 1 = read, 0 = write.
- mem_addr, out, ADDR_W: access address.
- mem_din, out, 16: write data to SDRAM.
- mem_dout, in, 32: read data; {odd pixel, even pixel}.
- mem_ack, in, 1: one-cycle strobe on read-data-valid or write-done.

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT. At most one access is outstanding.
- Write capture: wr_req with wr_busy=0 latches wr_addr/wr_data and sets the pending flag. wr_req while wr_busy=1 is ignored.
- Read eligibility: prefetch enabled, and (FIFO count + outstanding reads) < FIFO_DEPTH.
- Arbitration in IDLE:
  - Write pending and read eligible with count >= LOW_WATER: write goes first.
  - Write pending and read eligible with count < LOW_WATER: read goes first.
  - Only one candidate: issue it.
  - No candidate: stay in IDLE.
- Issue a write: mem_req=1, mem_rnw=0, mem_addr=latched address, mem_din=latched data; go to WR_WAIT.
- Issue a read: mem_req=1, mem_rnw=1, mem_addr=rd_ptr with bit 0 forced to 0; rd_ptr += 2 (wraps modulo 2^ADDR_W); go to RD_WAIT.
- WR_WAIT + mem_ack: clear pending; go to IDLE.
- RD_WAIT + mem_ack: push mem_dout unless the discard flag is set; clear discard; go to IDLE.
- Timeout: a counter restarts on every issue. Reaching TIMEOUT in either WAIT state sets err_timeout and returns to IDLE.
  - Write case: the write is dropped and pending is cleared.
  - Read case: nothing is pushed. rd_ptr is not rewound, so that pixel pair is lost.
- Pixel output: pix_data = low half of the FIFO head when half=0, high half when half=1.
  - pix_pop with pix_valid=1 and half=0: half <= 1.
  - pix_pop with pix_valid=1 and half=1: pop the entry, half <= 0.
  - pix_pop with pix_valid=0: increment underrun_cnt (saturating); no other change.
- frame_start:
  - Effects: FIFO emptied, half <= 0, rd_ptr <= {rd_base[ADDR_W-1:1], 0}, prefetch enabled, underrun_cnt <= 0.
  - In RD_WAIT: the discard flag is set, so the in-flight data is dropped.
  - In WR_WAIT: the write completes normally.
  - frame_start together with pix_pop: frame_start wins.
- mem_ack together with frame_start in RD_WAIT: the data is discarded.
- Push and pop in the same cycle: both apply; count is unchanged.

## Timing
- Reset values: wr_busy=0, pix_valid=0, pix_data=0, underrun_cnt=0, err_timeout=0, mem_req=0, mem_rnw=1, mem_addr=0, mem_din=0. FSM in IDLE, prefetch disabled, FIFO empty, half=0, discard=0.
- wr_req at cycle t: wr_busy=1 at t+1. mem_req is at t+1 at the earliest, when the FSM is IDLE and the write wins arbitration.
- mem_req is high exactly one cycle. mem_addr/mem_rnw/mem_din are held stable from the mem_req cycle until mem_ack or timeout.
- Earliest next issue is the cycle after mem_ack.
- Read path: mem_ack at t gives pix_valid=1 at t+1 (FIFO previously empty).
- Write path: mem_ack at t gives wr_busy=0 at t+1; a new wr_req is accepted at t+1.
- pix_data and pix_valid are registered outputs; they reflect a pop from cycle t at t+1.

## Test plan
- Reset, frame_start with rd_base=0x000101, mem_ack returned 3 cycles after each mem_req -> reads issued at 0x000100, 0x000102, ... and stop after 8 outstanding plus buffered; pix_valid rises 1 cycle after the first ack.
- Data 0xBBBBAAAA acked, then two pix_pop -> pix_data 0xAAAA, then 0xBBBB, then the entry is popped.
- FIFO at 5, write pending -> write issued first; drain FIFO to 1 with a write pending -> read issued first.
- frame_start during RD_WAIT, mem_ack carrying 0x12345678 -> nothing pushed; next read address equals new rd_base.
- No mem_ack for 255 cycles after a write -> err_timeout=1, wr_busy=0, FSM back in IDLE.
- 300 pops against an empty FIFO -> underrun_cnt=255; next frame_start -> 0.

Source files
------------

// File: rtl/overlay_sdram_arbiter.sv
// Purpose: shares SDRAM channel 1 between the overlay download writer and the pixel prefetcher.
// Latency: mem_req issues in the first IDLE cycle with a winner; read data reaches pix_valid 1 cycle after mem_ack.
// Backpressure: wr_busy_o holds off new writes; prefetch stalls while FIFO plus in-flight reads fill FIFO_DEPTH.
module overlay_sdram_arbiter #(
   parameter int ADDR_W     = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int LOW_WATER  = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [15:0]       wr_data_i,
   output logic              wr_busy_o,
   input  logic              frame_start_i,
   input  logic [ADDR_W-1:0] rd_base_i,
   input  logic              pix_pop_i,
   output logic              pix_valid_o,
   output logic [15:0]       pix_data_o,
   output logic [7:0]        underrun_cnt_o,
   output logic              err_timeout_o,
   output logic              mem_req_o,
   output logic              mem_rnw_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [15:0]       mem_din_o,
   input  logic [31:0]       mem_dout_i,
   input  logic              mem_ack_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

   state_t            state_q, state_d;
   logic              issue_wr, issue_rd, tmo_hit;
   logic [TW-1:0]     tmo_q;
   logic              pend_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rnw_q;
   logic [15:0]       din_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic              en_q;
   logic              discard_q;
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     widx_q, ridx_q;
   logic [CW-1:0]     count_q;
   logic              half_q;
   logic [7:0]        under_q;
   logic              err_q;

   logic              outstanding, rd_elig, wr_go, rd_go, push, pop;
   logic [CW:0]       level;
   logic [31:0]       head;

   // A read still in flight but marked for discard will never land, so it holds no FIFO slot.
   assign outstanding = (state_q == S_RD_WAIT) && !discard_q;
   assign level       = {1'b0, count_q} + {{CW{1'b0}}, outstanding};
   assign rd_elig     = en_q && (level < (CW+1)'(FIFO_DEPTH));
   // Writes win unless the display is close to starving.
   assign wr_go       = pend_q && (!rd_elig || (count_q >= CW'(LOW_WATER)));
   assign rd_go       = rd_elig && !wr_go;

   assign push = (state_q == S_RD_WAIT) && mem_ack_i && !discard_q && !frame_start_i;
   assign pop  = pix_pop_i && pix_valid_o && half_q && !frame_start_i;

   // Issue-cycle values come straight from registers; afterwards the latched copy holds the bus.
   assign mem_req_o  = issue_wr || issue_rd;
   assign mem_rnw_o  = issue_wr ? 1'b0 : (issue_rd ? 1'b1 : rnw_q);
   assign mem_addr_o = issue_wr ? wr_addr_q : (issue_rd ? rd_ptr_q : addr_q);
   assign mem_din_o  = issue_wr ? wr_data_q : din_q;

   assign wr_busy_o      = pend_q;
   assign head           = fifo_mem[ridx_q];
   assign pix_valid_o    = (count_q != '0);
   assign pix_data_o     = !pix_valid_o ? 16'h0000 : (half_q ? head[31:16] : head[15:0]);
   assign underrun_cnt_o = under_q;
   assign err_timeout_o  = err_q;

   // FSM state register.
   always_ff @(posedge clk_sys_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: arbitration in IDLE, ack or timeout ends a wait.
   always_comb begin
      state_d  = state_q;
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_go) begin
               state_d  = S_WR_WAIT;
               issue_wr = 1'b1;
            end else if (rd_go) begin
               state_d  = S_RD_WAIT;
               issue_rd = 1'b1;
            end
         end
         S_WR_WAIT, S_RD_WAIT: begin
            if (mem_ack_i) begin
               state_d = S_IDLE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               tmo_hit = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Prefetch storage; contents need no reset because count_q gates validity.
   always_ff @(posedge clk_sys_i) begin
      if (push) fifo_mem[widx_q] <= mem_dout_i;
   end

   // Control and datapath registers.
   always_ff @(posedge clk_sys_i) begin
      if (reset_i) begin
         tmo_q     <= '0;
         pend_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         addr_q    <= '0;
         rnw_q     <= 1'b1;
         din_q     <= '0;
         rd_ptr_q  <= '0;
         en_q      <= 1'b0;
         discard_q <= 1'b0;
         widx_q    <= '0;
         ridx_q    <= '0;
         count_q   <= '0;
         half_q    <= 1'b0;
         under_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (!pend_q && wr_req_i) begin
            pend_q    <= 1'b1;
            wr_addr_q <= wr_addr_i;
            wr_data_q <= wr_data_i;
         end else if ((state_q == S_WR_WAIT) && (mem_ack_i || tmo_hit)) begin
            pend_q <= 1'b0;
         end

         if (mem_req_o) begin
            addr_q <= mem_addr_o;
            rnw_q  <= mem_rnw_o;
            din_q  <= mem_din_o;
            tmo_q  <= '0;
         end else if (state_q != S_IDLE) begin
            tmo_q <= tmo_q + TW'(1);
         end

         if (tmo_hit) err_q <= 1'b1;

         // A timed-out read is not rewound: its pixel pair is simply lost.
         if (frame_start_i) begin
            rd_ptr_q <= rd_base_i & {{(ADDR_W-1){1'b1}}, 1'b0};
            en_q     <= 1'b1;
         end else if (issue_rd) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(2);
         end

         // Discard only matters for a read that is still open after this edge.
         if (state_d != S_RD_WAIT) discard_q <= 1'b0;
         else if (frame_start_i)   discard_q <= 1'b1;

         if (frame_start_i) begin
            widx_q  <= '0;
            ridx_q  <= '0;
            count_q <= '0;
            half_q  <= 1'b0;
            under_q <= '0;
         end else begin
            if (push) widx_q <= widx_q + PW'(1);
            if (pop)  ridx_q <= ridx_q + PW'(1);
            count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            if (pix_pop_i && pix_valid_o) half_q <= !half_q;
            if (pix_pop_i && !pix_valid_o && (under_q != 8'hFF)) under_q <= under_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_overlay_sdram_arbiter.sv
// Purpose: directed self-checking bench for overlay_sdram_arbiter with a fixed-latency SDRAM responder.
// Latency: responder acks 3 cycles after each mem_req; outputs are sampled 3 time units after posedge.
// Backpressure: responder can be muted to force access timeouts.
module tb_overlay_sdram_arbiter;

   logic        clk = 1'b0;
   logic        reset, wr_req, frame_start, pix_pop, mem_ack;
   logic [23:0] wr_addr, rd_base, mem_addr;
   logic [15:0] wr_data, pix_data, mem_din;
   logic [31:0] mem_dout;
   logic        wr_busy, pix_valid, err_timeout, mem_req, mem_rnw;
   logic [7:0]  underrun_cnt;

   int tests = 0;
   int fails = 0;

   logic        resp_en, ov_en;
   logic [23:0] ov_addr, cur_addr;
   logic [31:0] ov_data;
   int          dly;
   logic [23:0] rd_log[$];
   logic [23:0] wr_log[$];

   overlay_sdram_arbiter dut (
      .clk_sys_i      (clk),
      .reset_i        (reset),
      .wr_req_i       (wr_req),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .wr_busy_o      (wr_busy),
      .frame_start_i  (frame_start),
      .rd_base_i      (rd_base),
      .pix_pop_i      (pix_pop),
      .pix_valid_o    (pix_valid),
      .pix_data_o     (pix_data),
      .underrun_cnt_o (underrun_cnt),
      .err_timeout_o  (err_timeout),
      .mem_req_o      (mem_req),
      .mem_rnw_o      (mem_rnw),
      .mem_addr_o     (mem_addr),
      .mem_din_o      (mem_din),
      .mem_dout_i     (mem_dout),
      .mem_ack_i      (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SDRAM model: acks 3 cycles after a request; read data is {addr+1, addr} unless overridden.
   initial begin
      mem_ack  = 1'b0;
      mem_dout = '0;
      dly      = 0;
      cur_addr = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack = 1'b0;
         if (reset) begin
            dly = 0;
         end else begin
            if (dly > 0) begin
               dly--;
               if (dly == 0) begin
                  mem_ack  = 1'b1;
                  mem_dout = (ov_en && cur_addr == ov_addr) ? ov_data
                             : {16'(cur_addr + 24'd1), cur_addr[15:0]};
               end
            end
            if (mem_req) begin
               cur_addr = mem_addr;
               if (mem_rnw) rd_log.push_back(mem_addr);
               else         wr_log.push_back(mem_addr);
               if (resp_en) dly = 3;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      frame_start = 1'b0; rd_base = '0; pix_pop = 1'b0;
      resp_en = 1'b1; ov_en = 1'b0; ov_addr = '0; ov_data = '0;
      repeat (3) tick();

      // Reset values.
      chk("rst_wr_busy",   wr_busy, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data",  pix_data, 0);
      chk("rst_underrun",  underrun_cnt, 0);
      chk("rst_err",       err_timeout, 0);
      chk("rst_mem_req",   mem_req, 0);
      chk("rst_mem_rnw",   mem_rnw, 1);
      chk("rst_mem_addr",  mem_addr, 0);
      chk("rst_mem_din",   mem_din, 0);
      reset = 1'b0;
      repeat (5) tick();
      chk("no_prefetch_before_frame", rd_log.size(), 0);

      // Frame start at odd base: reads from 0x100 upward.
      ov_en = 1'b1; ov_addr = 24'h000100; ov_data = 32'hBBBBAAAA;
      rd_base = 24'h000101; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("rd0_req",  mem_req, 1);
      chk("rd0_rnw",  mem_rnw, 1);
      chk("rd0_addr", mem_addr, 24'h000100);
      for (int i = 0; i < 20 && mem_ack !== 1'b1; i++) tick();
      chk("ack0_seen", mem_ack, 1);
      chk("valid_in_ack_cycle", pix_valid, 0);
      tick();
      chk("valid_after_ack", pix_valid, 1);
      chk("pix_lo", pix_data, 16'hAAAA);
      repeat (60) tick();
      chk("rd_count_full", rd_log.size(), 8);
      for (int i = 0; i < 8 && i < rd_log.size(); i++)
         chk("rd_addr_seq", rd_log[i], 24'h000100 + 24'(2 * i));
      chk("idle_when_full", mem_req, 0);
      chk("addr_held_idle", mem_addr, 24'h00010E);

      // Two pops: high half, then next entry; one slot frees a new read.
      pix_pop = 1'b1;
      tick();
      chk("pix_hi", pix_data, 16'hBBBB);
      tick();
      pix_pop = 1'b0;
      chk("pix_next_entry", pix_data, 16'h0102);
      chk("refill_req",  mem_req, 1);
      chk("refill_addr", mem_addr, 24'h000110);

      // Frame start during RD_WAIT: in-flight data dropped, restart at new base.
      repeat (10) tick();
      ov_addr = 24'h000112; ov_data = 32'h12345678;
      pix_pop = 1'b1;
      tick();
      tick();
      pix_pop = 1'b0;
      chk("d_req",  mem_req, 1);
      chk("d_addr", mem_addr, 24'h000112);
      tick();
      frame_start = 1'b1; rd_base = 24'h000300;
      tick();
      frame_start = 1'b0;
      chk("flush_valid", pix_valid, 0);
      for (int i = 0; i < 10 && mem_req !== 1'b1; i++) tick();
      chk("d_new_req",  mem_req, 1);
      chk("d_new_addr", mem_addr, 24'h000300);
      for (int i = 0; i < 10 && pix_valid !== 1'b1; i++) tick();
      chk("d_valid", pix_valid, 1);
      chk("d_not_discarded_data", pix_data, 16'h0300);

      // Arbitration: count 1 -> read first, count 2 -> write first, count 5 -> write first.
      ov_en = 1'b0;
      repeat (60) tick();
      rd_base = 24'h000400; frame_start = 1'b1;
      rd_log.delete(); wr_log.delete();
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 20 && !(mem_ack === 1'b1 && rd_log.size() == 1); i++) tick();
      chk("e_ack1_seen", mem_ack, 1);
      wr_req = 1'b1; wr_addr = 24'h5A5A5A; wr_data = 16'hC0DE;
      tick();
      wr_req = 1'b0;
      chk("e_busy",       wr_busy, 1);
      chk("e_lw_req",     mem_req, 1);
      chk("e_lw_rnw",     mem_rnw, 1);
      chk("e_lw_addr",    mem_addr, 24'h000402);
      for (int i = 0; i < 20 && !(mem_ack === 1'b1 && rd_log.size() == 2); i++) tick();
      chk("e_ack2_seen", mem_ack, 1);
      tick();
      chk("e_wr_req",  mem_req, 1);
      chk("e_wr_rnw",  mem_rnw, 0);
      chk("e_wr_addr", mem_addr, 24'h5A5A5A);
      chk("e_wr_din",  mem_din, 16'hC0DE);
      tick();
      for (int i = 0; i < 10 && mem_ack !== 1'b1; i++) tick();
      chk("e_wr_ack_seen", mem_ack, 1);
      tick();
      chk("e_busy_cleared", wr_busy, 0);
      for (int i = 0; i < 40 && !(mem_ack === 1'b1 && rd_log.size() == 5); i++) tick();
      chk("e_ack5_seen", mem_ack, 1);
      wr_req = 1'b1; wr_addr = 24'h000777; wr_data = 16'h1234;
      tick();
      wr_req = 1'b0;
      chk("e_c5_rnw",  mem_rnw, 0);
      chk("e_c5_addr", mem_addr, 24'h000777);

      // Write timeout with muted responder.
      repeat (60) tick();
      resp_en = 1'b0;
      wr_req = 1'b1; wr_addr = 24'h000010; wr_data = 16'hBEEF;
      tick();
      wr_req = 1'b0;
      chk("t_req",  mem_req, 1);
      chk("t_rnw",  mem_rnw, 0);
      repeat (255) tick();
      chk("t_err_before",  err_timeout, 0);
      chk("t_busy_before", wr_busy, 1);
      chk("t_addr_held",   mem_addr, 24'h000010);
      tick();
      chk("t_err",     err_timeout, 1);
      chk("t_busy",    wr_busy, 0);
      chk("t_mem_req", mem_req, 0);
      resp_en = 1'b1;
      wr_req = 1'b1; wr_addr = 24'h000020; wr_data = 16'h5555;
      tick();
      wr_req = 1'b0;
      chk("t_idle_accepts", mem_req, 1);
      chk("t_idle_addr",    mem_addr, 24'h000020);
      repeat (10) tick();
      chk("t_err_sticky", err_timeout, 1);

      // Underrun saturation on empty FIFO with prefetch disabled.
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      chk("u_err_reset", err_timeout, 0);
      pix_pop = 1'b1;
      repeat (10) tick();
      chk("u_cnt10", underrun_cnt, 10);
      repeat (290) tick();
      chk("u_cnt_sat", underrun_cnt, 255);
      frame_start = 1'b1; rd_base = 24'h000000;
      tick();
      frame_start = 1'b0; pix_pop = 1'b0;
      chk("u_cleared", underrun_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
